// File: rtl/rr_arb8_if.sv
// rr_arb8_if: request/grant bundle between requesters and the round-robin arbiter.
//   en       arbiter enable (requester side drives)
//   req[7:0] request vector (requester side drives)
//   gnt[7:0] one-hot grant (arbiter drives)
//   gnt_idx  index of current owner, meaningful when gnt_vld is high (arbiter drives)
//   gnt_vld  high exactly when gnt is non-zero (arbiter drives)
interface rr_arb8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;

  modport master (output en, req, input gnt, gnt_idx, gnt_vld);
  modport slave  (input en, req, output gnt, gnt_idx, gnt_vld);
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: eight-requester round-robin arbiter with a bounded hold time.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   arb      rr_arb8_if.slave: en/req in, registered gnt/gnt_idx/gnt_vld out
//   MAX_HOLD max consecutive cycles an owner keeps the grant while others wait (1..255)
module rr_arb8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb8_if.slave    arb
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned HW = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
  logic [N-1:0]    gnt_q, gnt_nxt;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic            vld_q, vld_nxt;

  logic [N-1:0]    masked_c;
  logic [IW-1:0]   win_req_c, win_masked_c;

  // First set bit of v scanning circularly from p.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      idx = p + IW'(i);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    masked_c     = arb.req & ~(N'(1) << owner);
    win_req_c    = rr_pick(arb.req, ptr);
    win_masked_c = rr_pick(masked_c, ptr);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt_q;
    idx_nxt      = idx_q;
    vld_nxt      = vld_q;

    unique case (state)
      IDLE: begin
        gnt_nxt = '0;
        idx_nxt = '0;
        vld_nxt = 1'b0;
        if (arb.en && (|arb.req)) begin
          state_nxt    = GRANT;
          ptr_nxt      = win_req_c + IW'(1);
          owner_nxt    = win_req_c;
          hold_cnt_nxt = HW'(1);
          gnt_nxt      = N'(1) << win_req_c;
          idx_nxt      = win_req_c;
          vld_nxt      = 1'b1;
        end
      end
      GRANT: begin
        if (!arb.en) begin
          // Drop the grant but keep ptr/hold_cnt untouched.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          idx_nxt   = '0;
          vld_nxt   = 1'b0;
        end else if (!arb.req[owner]) begin
          // Release: hand over in the same edge when anyone else is waiting.
          if (|arb.req) begin
            ptr_nxt      = win_req_c + IW'(1);
            owner_nxt    = win_req_c;
            hold_cnt_nxt = HW'(1);
            gnt_nxt      = N'(1) << win_req_c;
            idx_nxt      = win_req_c;
            vld_nxt      = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
            vld_nxt   = 1'b0;
          end
        end else if (hold_cnt == HW'(MAX_HOLD)) begin
          // Hold budget spent: preempt if someone else is waiting, else saturate.
          if (|masked_c) begin
            ptr_nxt      = win_masked_c + IW'(1);
            owner_nxt    = win_masked_c;
            hold_cnt_nxt = HW'(1);
            gnt_nxt      = N'(1) << win_masked_c;
            idx_nxt      = win_masked_c;
            vld_nxt      = 1'b1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt_q    <= gnt_nxt;
      idx_q    <= idx_nxt;
      vld_q    <= vld_nxt;
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_idx = idx_q;
  assign arb.gnt_vld = vld_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed scoreboard bench for rr_arb8 with MAX_HOLD=4.
module tb_rr_arb8;

  typedef struct {
    logic [7:0] gnt;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  rr_arb8_if bus ();

  rr_arb8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pop the oldest expectation and compare all three outputs against it.
  task automatic check_out();
    exp_t       e;
    logic [2:0] eidx;
    logic       evld;
    e    = exp_q.pop_front();
    eidx = 3'd0;
    for (int i = 0; i < 8; i++) if (e.gnt[i]) eidx = 3'(i);
    evld = |e.gnt;
    checks++;
    assert (bus.gnt === e.gnt) else begin
      failures++;
      $error("FAIL %s gnt act=%h exp=%h", e.tag, bus.gnt, e.gnt);
    end
    checks++;
    assert (bus.gnt_idx === eidx) else begin
      failures++;
      $error("FAIL %s gnt_idx act=%0d exp=%0d", e.tag, bus.gnt_idx, eidx);
    end
    checks++;
    assert (bus.gnt_vld === evld) else begin
      failures++;
      $error("FAIL %s gnt_vld act=%b exp=%b", e.tag, bus.gnt_vld, evld);
    end
  endtask

  // Expect e_gnt after the next rising edge.
  task automatic cyc(input logic [7:0] e_gnt, input string tag);
    exp_t e;
    e.gnt = e_gnt;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Expect e_gnt right now, without a clock edge.
  task automatic now(input logic [7:0] e_gnt, input string tag);
    exp_t e;
    e.gnt = e_gnt;
    e.tag = tag;
    exp_q.push_back(e);
    check_out();
  endtask

  initial begin
    logic [7:0] one;
    one      = 8'h01;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.req  = 8'hFF;

    // Reset held with all requests pending.
    repeat (3) @(posedge clk);
    #1;
    now(8'h00, "reset_hold");

    // Release away from an edge; first edge grants requester 0.
    #2 rst_n = 1'b1;
    // Full rotation: each owner holds 4 cycles, 0..7 then wrap to 0,1.
    for (int c = 1; c <= 40; c++) cyc(one << 3'(((c - 1) / 4) % 8), "rotation");

    // Owner 1 releases; requester 5 alone, saturates with no preemption.
    bus.req = 8'h20;
    for (int c = 0; c < 20; c++) cyc(8'h20, "single_sat");

    // en low for a cycle -> IDLE, ptr stays 6.
    bus.en = 1'b0;
    cyc(8'h00, "en_drop");
    bus.en  = 1'b1;
    bus.req = 8'h04;
    cyc(8'h04, "grant2");          // owner 2, ptr 3
    bus.req = 8'h84;
    cyc(8'h04, "hold2");
    bus.req = 8'h80;
    cyc(8'h80, "handover7");       // no bubble, ptr wraps to 0

    // Build ptr=6 then present 8'h41 from IDLE.
    bus.req = 8'h20;
    cyc(8'h20, "grant5");          // ptr 6
    bus.req = 8'h00;
    cyc(8'h00, "idle");
    bus.req = 8'h41;
    for (int c = 0; c < 4; c++) cyc(8'h40, "fair6");
    cyc(8'h01, "preempt0");        // ptr 1

    // Grant index 3, drop en one cycle, resume using retained ptr=4.
    bus.req = 8'h08;
    cyc(8'h08, "grant3");
    cyc(8'h08, "hold3");
    bus.en = 1'b0;
    cyc(8'h00, "en_pulse");
    bus.en  = 1'b1;
    bus.req = 8'h28;               // ptr 4 scans 4,5 -> 5 wins
    cyc(8'h20, "resume_ptr");
    cyc(8'h20, "resume_hold");

    // Asynchronous reset mid-grant, between edges.
    #2 rst_n = 1'b0;
    #1;
    now(8'h00, "async_rst");
    bus.req = 8'hFF;
    cyc(8'h00, "rst_edge");
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) cyc(8'h01, "post_rst0");
    cyc(8'h02, "post_rst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
